// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared constants, coefficient table and FSM states
// for the dual-channel decimating FIR scheduler.
package fir_sched_pkg;

    localparam int AUDIO_LPR_COEFF_TAPS = 32;
    localparam int AUDIO_DECIM          = 8;
    localparam int QUANT_BITS           = 10;
    localparam int COEFF_WIDTH          = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MAC   = 2'd2,
        S_WRITE = 2'd3
    } sched_state_t;

    // Tap 31 first; tap k sits at [k*32 +: 32]. Taps sum to 4520.
    localparam logic [AUDIO_LPR_COEFF_TAPS*COEFF_WIDTH-1:0] AUDIO_LPR_COEFFS = {
        -32'sd3,   -32'sd8,   -32'sd11,  -32'sd14,
        -32'sd16,  -32'sd15,  -32'sd13,  32'sd0,
        32'sd21,   32'sd30,   32'sd80,   32'sd150,
        32'sd393,  32'sd500,  32'sd600,  32'sd579,
        32'sd579,  32'sd600,  32'sd500,  32'sd393,
        32'sd150,  32'sd80,   32'sd30,   32'sd0,
        -32'sd13,  -32'sd15,  -32'sd16,  -32'sd14,
        -32'sd11,  -32'sd8,   -32'sd5,   -32'sd3
    };

endpackage

// File: rtl/fir_rr_arbiter.sv
// fir_rr_arbiter: two-requester round-robin; on contention the channel
// not served last wins. Pointer state advances only when a grant is taken.
module fir_rr_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);

    logic last;

    always_comb begin
        unique case (req)
            2'b11:   grant = ~last;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    // Starts as "ch1 served last" so ch0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (advance) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/fir_dual_sched.sv
// fir_dual_sched: one decimating FIR MAC shared round-robin by two channels.
// Define FIR_SAT_EN to saturate the quantized output instead of wrapping.
module fir_dual_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = fir_sched_pkg::AUDIO_LPR_COEFF_TAPS,
    parameter int DECIMATION = fir_sched_pkg::AUDIO_DECIM,
    parameter int QUANT_BITS = fir_sched_pkg::QUANT_BITS,
    parameter logic [TAPS*DATA_WIDTH-1:0] COEFF = fir_sched_pkg::AUDIO_LPR_COEFFS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x0_in,
    input  logic                  x0_empty,
    output logic                  x0_rd_en,
    input  logic [DATA_WIDTH-1:0] x1_in,
    input  logic                  x1_empty,
    output logic                  x1_rd_en,
    output logic [DATA_WIDTH-1:0] y_out,
    input  logic                  y0_full,
    output logic                  y0_wr_en,
    input  logic                  y1_full,
    output logic                  y1_wr_en,
    output logic                  busy,
    output logic                  active_ch
);

    import fir_sched_pkg::*;

    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int LW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int AW = 2 * DATA_WIDTH;
    localparam logic [KW-1:0] LAST_TAP  = KW'(TAPS - 1);
    localparam logic [LW-1:0] LAST_LOAD = LW'(DECIMATION - 1);

    sched_state_t state;

    logic [KW-1:0] tap_idx;
    logic [LW-1:0] load_cnt;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] coef_x;
    logic signed [AW-1:0] samp_x;

    logic signed [DATA_WIDTH-1:0] hist0 [TAPS];
    logic signed [DATA_WIDTH-1:0] hist1 [TAPS];
    logic signed [DATA_WIDTH-1:0] coef_tab [TAPS];
    logic signed [DATA_WIDTH-1:0] sample;

    logic [DATA_WIDTH-1:0] y_next;
    logic [1:0]            req;
    logic                  grant;
    logic                  advance;
    logic                  pop;
    logic                  push;

    for (genvar k = 0; k < TAPS; k++) begin : g_coef
        assign coef_tab[k] = COEFF[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign req     = {~x1_empty, ~x0_empty};
    assign advance = (state == S_IDLE) && (|req);

    fir_rr_arbiter u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    assign x0_rd_en = (state == S_LOAD) && !active_ch && !x0_empty;
    assign x1_rd_en = (state == S_LOAD) &&  active_ch && !x1_empty;
    assign y0_wr_en = (state == S_WRITE) && !active_ch && !y0_full;
    assign y1_wr_en = (state == S_WRITE) &&  active_ch && !y1_full;
    assign pop      = x0_rd_en | x1_rd_en;
    assign push     = y0_wr_en | y1_wr_en;
    assign busy     = (state != S_IDLE);

    assign sample   = active_ch ? hist1[tap_idx] : hist0[tap_idx];
    assign coef_x   = AW'(coef_tab[tap_idx]);
    assign samp_x   = AW'(sample);
    assign prod     = coef_x * samp_x;
    assign acc_next = acc + prod;

`ifdef FIR_SAT_EN
    logic signed [AW-1:0] shifted;
    logic signed [AW-1:0] sat_hi;
    logic signed [AW-1:0] sat_lo;

    assign shifted = acc_next >>> QUANT_BITS;
    assign sat_hi  = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    assign sat_lo  = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        if (shifted > sat_hi) begin
            y_next = sat_hi[DATA_WIDTH-1:0];
        end else if (shifted < sat_lo) begin
            y_next = sat_lo[DATA_WIDTH-1:0];
        end else begin
            y_next = shifted[DATA_WIDTH-1:0];
        end
    end
`else
    assign y_next = DATA_WIDTH'(acc_next >>> QUANT_BITS);
`endif

    // Newest sample lands in slot 0 on every pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                hist0[i] <= '0;
                hist1[i] <= '0;
            end
        end else begin
            if (x0_rd_en) begin
                hist0[0] <= x0_in;
                for (int i = 1; i < TAPS; i++) begin
                    hist0[i] <= hist0[i-1];
                end
            end
            if (x1_rd_en) begin
                hist1[0] <= x1_in;
                for (int i = 1; i < TAPS; i++) begin
                    hist1[i] <= hist1[i-1];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            active_ch <= 1'b0;
            load_cnt  <= '0;
            tap_idx   <= '0;
            acc       <= '0;
            y_out     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (advance) begin
                        active_ch <= grant;
                        load_cnt  <= '0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (pop) begin
                        if (load_cnt == LAST_LOAD) begin
                            acc     <= '0;
                            tap_idx <= '0;
                            state   <= S_MAC;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (tap_idx == LAST_TAP) begin
                        y_out <= y_next;
                        state <= S_WRITE;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (push) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_dual_sched.sv
// tb_fir_dual_sched: directed scenarios against fir_dual_sched with FWFT
// FIFO models and a per-channel expected-output scoreboard.
module tb_fir_dual_sched;

    import fir_sched_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] x0_in, x1_in, y_out;
    logic        x0_empty, x1_empty, x0_rd_en, x1_rd_en;
    logic        y0_full, y1_full, y0_wr_en, y1_wr_en;
    logic        busy, active_ch;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops0 = 0, pops1 = 0, lastpop0 = 0, lastpop1 = 0;
    bit chk_lat = 1'b0;
    bit pend0 = 1'b0, pend1 = 1'b0;

    logic [31:0] fq0[$], fq1[$];
    logic [31:0] exp0[$], exp1[$];
    logic [31:0] got0[$], got1[$];
    int          wr_log[$];

    logic [1023:0] coeffs;
    longint        mh[2][32];
    int            mcnt[2];

    always #5 clock = ~clock;

    fir_dual_sched dut (
        .clock     (clock),
        .reset     (reset),
        .x0_in     (x0_in),
        .x0_empty  (x0_empty),
        .x0_rd_en  (x0_rd_en),
        .x1_in     (x1_in),
        .x1_empty  (x1_empty),
        .x1_rd_en  (x1_rd_en),
        .y_out     (y_out),
        .y0_full   (y0_full),
        .y0_wr_en  (y0_wr_en),
        .y1_full   (y1_full),
        .y1_wr_en  (y1_wr_en),
        .busy      (busy),
        .active_ch (active_ch)
    );

    function automatic logic [31:0] model_out(input int ch);
        longint acc;
        longint sh;
        longint c;
        acc = 0;
        for (int k = 0; k < 32; k++) begin
            c = longint'($signed(coeffs[k*32 +: 32]));
            acc = acc + c * mh[ch][k];
        end
        sh = acc >>> 10;
`ifdef FIR_SAT_EN
        if (sh > longint'(32'h7FFFFFFF)) return 32'h7FFFFFFF;
        if (sh < -longint'(32'h80000000)) return 32'h80000000;
`endif
        return sh[31:0];
    endfunction

    task automatic push_sample(input int ch, input logic [31:0] v);
        for (int k = 31; k > 0; k--) mh[ch][k] = mh[ch][k-1];
        mh[ch][0] = longint'($signed(v));
        mcnt[ch]++;
        if (ch == 0) begin
            fq0.push_back(v);
            if (mcnt[0] % 8 == 0) exp0.push_back(model_out(0));
        end else begin
            fq1.push_back(v);
            if (mcnt[1] % 8 == 0) exp1.push_back(model_out(1));
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mcnt[c] = 0;
            for (int k = 0; k < 32; k++) mh[c][k] = 0;
        end
        exp0.delete();
        exp1.delete();
        pops0 = 0;
        pops1 = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(expv), expv);
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while ((fq0.size() != 0 || fq1.size() != 0 || exp0.size() != 0 ||
                exp1.size() != 0 || busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL %s_timeout: waited %0d cycles, limit %0d", tag, n, budget);
        end
    endtask

    task automatic score(input int ch);
        logic [31:0] e;
        int          sz;
        int          lat;
        sz = (ch == 0) ? exp0.size() : exp1.size();
        checks++;
        assert (sz != 0) else begin
            errors++;
            $error("FAIL y%0d_unexpected: observed write of %0d, expected none",
                   ch, $signed(y_out));
        end
        if (sz != 0) begin
            e = (ch == 0) ? exp0.pop_front() : exp1.pop_front();
            checks++;
            assert (y_out === e) else begin
                errors++;
                $error("FAIL y%0d_data: observed %0d expected %0d",
                       ch, $signed(y_out), $signed(e));
            end
        end
        wr_log.push_back(ch);
        if (ch == 0) got0.push_back(y_out);
        else got1.push_back(y_out);
        if (chk_lat) begin
            lat = cyc - ((ch == 0) ? lastpop0 : lastpop1);
            checks++;
            assert (lat === 33) else begin
                errors++;
                $error("FAIL y%0d_latency: observed %0d cycles expected 33", ch, lat);
            end
        end
    endtask

    // FWFT FIFO models: a pop seen before the edge takes effect after it.
    always @(negedge clock) begin
        pend0 = x0_rd_en;
        pend1 = x1_rd_en;
    end

    always @(posedge clock) begin
        #1;
        if (pend0 && fq0.size() != 0) void'(fq0.pop_front());
        if (pend1 && fq1.size() != 0) void'(fq1.pop_front());
        pend0 = 1'b0;
        pend1 = 1'b0;
        x0_empty = (fq0.size() == 0);
        x1_empty = (fq1.size() == 0);
        x0_in = x0_empty ? 32'd0 : fq0[0];
        x1_in = x1_empty ? 32'd0 : fq1[0];
    end

    always @(negedge clock) begin
        cyc++;
        if (reset === 1'b1) begin
            checks++;
            assert ($countones({x0_rd_en, x1_rd_en, y0_wr_en, y1_wr_en}) <= 1)
            else begin
                errors++;
                $error("FAIL strobe_excl: observed %b expected at most one high",
                       {x0_rd_en, x1_rd_en, y0_wr_en, y1_wr_en});
            end
            if (x0_rd_en) begin
                pops0++;
                if (pops0 % 8 == 0) lastpop0 = cyc;
            end
            if (x1_rd_en) begin
                pops1++;
                if (pops1 % 8 == 0) lastpop1 = cyc;
            end
            if (y0_wr_en) score(0);
            if (y1_wr_en) score(1);
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sat_exp;
        longint      big;

        coeffs   = AUDIO_LPR_COEFFS;
        reset    = 1'b0;
        x0_in    = '0;
        x1_in    = '0;
        x0_empty = 1'b1;
        x1_empty = 1'b1;
        y0_full  = 1'b0;
        y1_full  = 1'b0;
        model_reset();

        repeat (3) @(negedge clock);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_active_ch", {31'd0, active_ch}, 0);
        check("rst_y_out", y_out, 0);
        check("rst_strobes", {28'd0, x0_rd_en, x1_rd_en, y0_wr_en, y1_wr_en}, 0);
        reset = 1'b1;

        // 1: ch0 impulse
        chk_lat = 1'b1;
        got0.delete();
        push_sample(0, 32'd1024);
        for (int i = 0; i < 31; i++) push_sample(0, 32'd0);
        wait_drain("t1", 2000);
        check("t1_count", got0.size(), 4);
        check("t1_out0", got0[0], -13);
        check("t1_out1", got0[1], 579);
        check("t1_out2", got0[2], 21);
        check("t1_out3", got0[3], -3);

        // 2: ch1 DC
        got1.delete();
        for (int i = 0; i < 48; i++) push_sample(1, 32'd1024);
        wait_drain("t2", 3000);
        check("t2_count", got1.size(), 6);
        for (int i = 3; i < 6; i++) check("t2_dc_gain", got1[i], 4520);

        // 3: both channels pre-filled
        wr_log.delete();
        for (int i = 0; i < 16; i++) begin
            push_sample(0, $urandom());
            push_sample(1, $urandom());
        end
        wait_drain("t3", 3000);
        check("t3_count", wr_log.size(), 4);
        check("t3_order0", wr_log[0], 0);
        check("t3_order1", wr_log[1], 1);
        check("t3_order2", wr_log[2], 0);
        check("t3_order3", wr_log[3], 1);

        // 4: ch0 output FIFO full while ch1 has data waiting
        chk_lat = 1'b0;
        @(posedge clock);
        #1;
        y0_full = 1'b1;
        for (int i = 0; i < 8; i++) push_sample(0, $urandom_range(0, 65535));
        repeat (60) @(negedge clock);
        for (int i = 0; i < 8; i++) push_sample(1, $urandom_range(0, 65535));
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("t4_hold", {29'd0, y0_wr_en, busy, x1_rd_en}, 32'b010);
        end
        @(posedge clock);
        #1;
        y0_full = 1'b0;
        @(negedge clock);
        check("t4_release_wr", {31'd0, y0_wr_en}, 1);
        @(negedge clock);
        check("t4_single_pulse", {31'd0, y0_wr_en}, 0);
        chk_lat = 1'b1;
        for (int i = 0; i < 5 && !x1_rd_en; i++) @(negedge clock);
        check("t4_ch1_pop", {31'd0, x1_rd_en}, 1);
        check("t4_ch1_grant", {31'd0, active_ch}, 1);
        wait_drain("t4", 2000);

        // 5: reset during MAC, then repeat the impulse run
        push_sample(0, 32'd1024);
        for (int i = 0; i < 7; i++) push_sample(0, 32'd0);
        repeat (25) @(negedge clock);
        check("t5_busy_pre", {31'd0, busy}, 1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_y_out", y_out, 0);
        check("t5_rst_busy", {31'd0, busy}, 0);
        check("t5_rst_active_ch", {31'd0, active_ch}, 0);
        check("t5_rst_strobes", {28'd0, x0_rd_en, x1_rd_en, y0_wr_en, y1_wr_en}, 0);
        model_reset();
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        got0.delete();
        push_sample(0, 32'd1024);
        for (int i = 0; i < 31; i++) push_sample(0, 32'd0);
        wait_drain("t5", 2000);
        check("t5_count", got0.size(), 4);
        check("t5_out0", got0[0], -13);
        check("t5_out1", got0[1], 579);
        check("t5_out2", got0[2], 21);
        check("t5_out3", got0[3], -3);

        // 6: full-scale DC on ch0
        got0.delete();
        for (int i = 0; i < 32; i++) push_sample(0, 32'h7FFFFFFF);
        wait_drain("t6", 2000);
`ifdef FIR_SAT_EN
        sat_exp = 32'h7FFFFFFF;
`else
        big = longint'(4520) * longint'(32'h7FFFFFFF);
        big = big >>> 10;
        sat_exp = big[31:0];
`endif
        check("t6_count", got0.size(), 4);
        check("t6_full_scale", got0[3], sat_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
